camera_cfg_sequencer: RTL and testbench
=======================================

// Module: camera_cfg_sequencer
// PURPOSE
//  Reads the OV7670 configuration ROM from address 0 upward and turns each 16-bit word {reg,data} into one SCCB write request.
//  Sits between the config ROM and the SCCB write master, and brings the camera up after reset.
//  Honours two in-band markers: 16'hFFF0 = timed delay, 16'hFFFF = end of table.
// PARAMETERS
//  DELAY_CYCLES  240_000  clocks waited on a 16'hFFF0 entry (10 ms at 24 MHz)
//  ROM_LAT       1        clocks from o_rom_addr change to valid i_rom_dout (registered ROM)
//  AUTO_START    1        1: sequence starts by itself after reset; 0: waits for i_start
//  MAX_RETRY     3        retries per entry on NACK (used only with CAM_CFG_RETRY_EN)
// PORTS
//  i_clk          in   1   system clock
//  i_rstn         in   1   asynchronous active-low reset
//  i_start        in   1   one-cycle pulse: (re)run the table from address 0; honoured only in IDLE/DONE
//  o_rom_addr     out  8   config ROM address
//  i_rom_dout     in   16  config ROM word {reg[15:8], data[7:0]}
//  o_sccb_start   out  1   write request valid
//  o_sccb_reg     out  8   SCCB register address
//  o_sccb_data    out  8   SCCB write data
//  i_sccb_ready   in   1   master accepts the request in a cycle where start&&ready
//  i_sccb_done    in   1   one-cycle pulse: the 3-phase write completed
//  i_sccb_nack    in   1   qualifies i_sccb_done: slave did not acknowledge
//  o_busy         out  1   sequence in progress
//  o_done         out  1   level: table finished; cleared by i_start
//  o_err          out  1   sticky: an entry failed (see CONFIGURATION); cleared by i_start
// BEHAVIOUR
//  Reset: o_rom_addr=0, o_sccb_start=0, o_sccb_reg/data=0, o_busy=0, o_done=0, o_err=0; state IDLE.
//   Reset mid-write abandons the request; the SCCB master resets from the same i_rstn.
//  FSM: IDLE -> FETCH -> WAIT_ROM -> DECODE -> {ISSUE | DELAY | DONE}
//   IDLE: leaves on i_start. With AUTO_START=1 it also leaves once, on the first clock after reset.
//   FETCH: drives o_rom_addr, then waits ROM_LAT clocks in WAIT_ROM; DECODE samples i_rom_dout.
//   DECODE: 16'hFFFF -> DONE; 16'hFFF0 -> DELAY; any other word -> latch reg/data -> ISSUE.
//   ISSUE: holds o_sccb_start=1 with reg/data stable until start&&ready, then drops start the next cycle -> WAIT_DONE.
//   WAIT_DONE: on i_sccb_done -> NEXT. DELAY: counts DELAY_CYCLES clocks -> NEXT.
//   NEXT: o_rom_addr+1 -> FETCH. If o_rom_addr==255 -> DONE; the address never wraps.
//   DONE: o_busy=0, o_done=1; i_start -> FETCH at address 0.
//  o_busy=1 in every state except IDLE and DONE. i_start while busy is ignored.
//  Latency per write entry = 2 + ROM_LAT + ready wait + SCCB time + 1 clocks.
//  Any i_sccb_done outside WAIT_DONE is ignored. i_rom_dout is not sampled outside DECODE.
// CONFIGURATION
//  CAM_CFG_RETRY_EN defined:
//   - done&&nack in WAIT_DONE re-enters ISSUE for the same entry, up to MAX_RETRY times.
//   - When retries are exhausted: set o_err and continue with the next entry.
//   - The retry counter is cleared on each new entry.
//  Not defined: i_sccb_nack is ignored, o_err is tied 0, and there is no retry counter.
// STRUCTURE
//  cam_cfg_pkg holds:
//   - the state enum cfg_state_t
//   - localparams CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0
//   - the ROM word split helpers (reg/data field slices)
//  Sub-module cam_cfg_timer: load/count-down timer, width $clog2(DELAY_CYCLES+1), output expired pulse.
//   Used for both the DELAY state and the ROM_LAT wait.
// TESTING (bench: behavioural ROM model, DELAY_CYCLES=16, ROM_LAT=1, SCCB model ready after 2 clk, done after 10 clk)
//  1. ROM {1280,FFF0,1204,FFFF}, AUTO_START=1, release reset.
//     -> writes (12,80) then (12,04); >=16 clk gap with no start between them; o_done=1 after the last done; exactly 2 writes.
//  2. Hold i_sccb_ready=0 for 50 clk during ISSUE.
//     -> o_sccb_start stays 1 and reg/data stay stable; exactly one acceptance.
//  3. Table of 256 plain entries with no FFFF.
//     -> 256 writes, o_rom_addr stops at 255, o_done=1, no wrap to 0.
//  4. Assert i_rstn low during WAIT_DONE of entry 5, then release.
//     -> all outputs at reset values; the run restarts at address 0.
//  5. i_start pulse while busy -> ignored; i_start pulse in DONE -> full rerun, o_done low until it finishes.
//  6. CAM_CFG_RETRY_EN, nack on every attempt for entry 2.
//     -> 1+3 attempts for that entry, then o_err=1, then the next entry is issued.
//     Without the macro: one attempt and o_err=0.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared state encoding, in-band ROM markers and ROM word field helpers
// for the OV7670 configuration sequencer.
package cam_cfg_pkg;

    // In-band markers stored in the configuration ROM.
    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StWaitRom,
        StDecode,
        StIssue,
        StWaitDone,
        StDelay,
        StNext,
        StDone
    } cfg_state_t;

    // ROM word layout is {reg[15:8], data[7:0]}.
    function automatic logic [7:0] cfg_reg(input logic [15:0] word);
        return word[15:8];
    endfunction

    function automatic logic [7:0] cfg_data(input logic [15:0] word);
        return word[7:0];
    endfunction

endpackage

// File: rtl/cam_cfg_timer.sv
// Load/count-down timer. Loading N makes expired_o pulse during the N-th
// cycle after the load, so a state entered right after the load lasts N cycles.
module cam_cfg_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q, count_d;

    // Reload has priority; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == Width'(1));

endmodule

// File: rtl/camera_cfg_sequencer.sv
// Walks the OV7670 configuration ROM from address 0 and turns each {reg,data}
// word into one SCCB write request; 16'hFFF0 inserts a timed delay and
// 16'hFFFF ends the table.
// Optional feature macro: CAM_CFG_RETRY_EN (retry NACKed writes, sticky o_err).
module camera_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 240_000,
    parameter int unsigned ROM_LAT      = 1,
    parameter bit          AUTO_START   = 1'b1,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_dout,
    output logic        o_sccb_start,
    output logic [7:0]  o_sccb_reg,
    output logic [7:0]  o_sccb_data,
    input  logic        i_sccb_ready,
    input  logic        i_sccb_done,
    input  logic        i_sccb_nack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    // One timer serves both the ROM latency wait and the table delay.
    localparam int unsigned TimerMax = (DELAY_CYCLES > ROM_LAT) ? DELAY_CYCLES : ROM_LAT;
    localparam int unsigned TimerW   = (TimerMax < 1) ? 1 : $clog2(TimerMax + 1);

    cfg_state_t        state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        data_q, data_d;
    logic              auto_q, auto_d;
    logic              tmr_load;
    logic [TimerW-1:0] tmr_val;
    logic              tmr_expired;

`ifdef CAM_CFG_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic              err_q, err_d;
    logic [RetryW-1:0] retry_q, retry_d;
`else
    logic unused_nack;
    assign unused_nack = i_sccb_nack ^ (MAX_RETRY == 0);
`endif

    cam_cfg_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i      (i_clk),
        .rst_ni     (i_rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Next-state logic; auto_q lets the sequence self-start exactly once after reset.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        reg_d    = reg_q;
        data_d   = data_q;
        auto_d   = auto_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef CAM_CFG_RETRY_EN
        err_d    = err_q;
        retry_d  = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start || auto_q) begin
                    state_d = StFetch;
                    addr_d  = '0;
                    auto_d  = 1'b0;
`ifdef CAM_CFG_RETRY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StFetch: begin
                if (ROM_LAT == 0) begin
                    state_d = StDecode;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = TimerW'(ROM_LAT);
                    state_d  = StWaitRom;
                end
            end
            StWaitRom: begin
                if (tmr_expired) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
`ifdef CAM_CFG_RETRY_EN
                retry_d = '0;
`endif
                if (i_rom_dout == CFG_END) begin
                    state_d = StDone;
                end else if (i_rom_dout == CFG_DELAY) begin
                    if (DELAY_CYCLES == 0) begin
                        state_d = StNext;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TimerW'(DELAY_CYCLES);
                        state_d  = StDelay;
                    end
                end else begin
                    reg_d   = cfg_reg(i_rom_dout);
                    data_d  = cfg_data(i_rom_dout);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (i_sccb_ready) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (i_sccb_done) begin
`ifdef CAM_CFG_RETRY_EN
                    if (i_sccb_nack && (retry_q < RetryW'(MAX_RETRY))) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StIssue;
                    end else begin
                        if (i_sccb_nack) begin
                            err_d = 1'b1;
                        end
                        state_d = StNext;
                    end
`else
                    state_d = StNext;
`endif
                end
            end
            StDelay: begin
                if (tmr_expired) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                // The address saturates at 255: a table without an end marker stops there.
                if (addr_q == 8'hFF) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                if (i_start) begin
                    state_d = StFetch;
                    addr_d  = '0;
`ifdef CAM_CFG_RETRY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            auto_q  <= AUTO_START;
`ifdef CAM_CFG_RETRY_EN
            err_q   <= 1'b0;
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            auto_q  <= auto_d;
`ifdef CAM_CFG_RETRY_EN
            err_q   <= err_d;
            retry_q <= retry_d;
`endif
        end
    end

    assign o_rom_addr   = addr_q;
    assign o_sccb_start = (state_q == StIssue);
    assign o_sccb_reg   = reg_q;
    assign o_sccb_data  = data_q;
    assign o_busy       = (state_q != StIdle) && (state_q != StDone);
    assign o_done       = (state_q == StDone);
`ifdef CAM_CFG_RETRY_EN
    assign o_err        = err_q;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// Scoreboard bench for camera_cfg_sequencer: a registered ROM model, an SCCB
// master model, directed tables with hand-computed expected writes.
module tb_camera_cfg_sequencer;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] d;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        ready;
    logic        done;
    logic        nack;
    logic        busy;
    logic        cfg_done;
    logic        err;

    logic [15:0] rom [256];
    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ready_delay = 2;
    int          nack_addr = -1;

    // Monitor bookkeeping.
    int          last_done_cyc = 0;
    int          last_gap = 0;
    int          issue_len = 0;
    int          last_issue_len = 0;
    int          accept_cnt = 0;
    logic        prev_start = 1'b0;
    logic        stable_ok = 1'b1;
    logic [15:0] first_rd = '0;

    // SCCB model state.
    int          wcnt;
    int          bcnt;
    logic        mbusy;

    camera_cfg_sequencer #(
        .DELAY_CYCLES (16),
        .ROM_LAT      (1),
        .AUTO_START   (1'b1),
        .MAX_RETRY    (3)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .o_rom_addr   (rom_addr),
        .i_rom_dout   (rom_dout),
        .o_sccb_start (sccb_start),
        .o_sccb_reg   (sccb_reg),
        .o_sccb_data  (sccb_data),
        .i_sccb_ready (ready),
        .i_sccb_done  (done),
        .i_sccb_nack  (nack),
        .o_busy       (busy),
        .o_done       (cfg_done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM, one clock of latency.
    always @(posedge clk) rom_dout <= rom[rom_addr];

    // SCCB master: ready after ready_delay clocks of request, done 10 clocks after accept.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready <= 1'b0;
            done  <= 1'b0;
            nack  <= 1'b0;
            wcnt  <= 0;
            bcnt  <= 0;
            mbusy <= 1'b0;
        end else begin
            done <= 1'b0;
            nack <= 1'b0;
            if (mbusy) begin
                if (bcnt == 1) begin
                    mbusy <= 1'b0;
                    done  <= 1'b1;
                    nack  <= (nack_addr == int'(rom_addr));
                end
                bcnt <= bcnt - 1;
            end else if (sccb_start && ready) begin
                ready <= 1'b0;
                wcnt  <= 0;
                mbusy <= 1'b1;
                bcnt  <= 10;
            end else if (sccb_start) begin
                wcnt <= wcnt + 1;
                if (wcnt + 1 >= ready_delay) ready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] d, input logic e);
        exp_t x;
        x.r = r;
        x.d = d;
        x.e = e;
        exp_q.push_back(x);
    endtask

    // Pops one expected write per accepted request (start && ready at the negedge).
    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_start = 1'b0;
                stable_ok  = 1'b1;
                issue_len  = 0;
            end else begin
                if (done) last_done_cyc = cyc;
                if (sccb_start) begin
                    if (!prev_start) begin
                        last_gap  = cyc - last_done_cyc;
                        issue_len = 0;
                        stable_ok = 1'b1;
                        first_rd  = {sccb_reg, sccb_data};
                    end else if ({sccb_reg, sccb_data} != first_rd) begin
                        stable_ok = 1'b0;
                    end
                    issue_len++;
                    if (ready) begin
                        vectors++;
                        accept_cnt++;
                        last_issue_len = issue_len;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL write: unexpected write reg=%h data=%h", sccb_reg,
                                     sccb_data);
                        end else begin
                            x = exp_q.pop_front();
                            if ({sccb_reg, sccb_data, err, stable_ok} != {x.r, x.d, x.e, 1'b1}) begin
                                miscompares++;
                                $display("FAIL write: got reg=%h data=%h err=%b stable=%b, want reg=%h data=%h err=%b stable=1",
                                         sccb_reg, sccb_data, err, stable_ok, x.r, x.d, x.e);
                            end
                        end
                    end
                end
                prev_start = sccb_start;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!cfg_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_rose"}, 32'(cfg_done), 32'd1);
    endtask

    task automatic check_reset(input string name);
        check({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({name, "_start"}, 32'(sccb_start), 32'd0);
        check({name, "_reg"}, 32'(sccb_reg), 32'd0);
        check({name, "_data"}, 32'(sccb_data), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(cfg_done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int attempts;
        logic [7:0] b;
        logic e3;

        fork
            monitor();
        join_none

        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

        // Test 1: write, delay marker, write, end marker; self-start after reset.
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
        push(8'h12, 8'h80, 1'b0);
        push(8'h12, 8'h04, 1'b0);
        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;
        wait_done("t1", 500);
        check("t1_writes_left", 32'(exp_q.size()), 32'd0);
        check("t1_gap_ge_16", 32'(last_gap >= 16), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_rom_addr", 32'(rom_addr), 32'd3);
        check("t1_err", 32'(err), 32'd0);

        // Tests 2 and 5: rerun from DONE with a slow master; a start while busy is ignored.
        rom[0] = 16'h3A04;
        rom[1] = 16'h4010;
        rom[2] = 16'hFFFF;
        ready_delay = 50;
        push(8'h3A, 8'h04, 1'b0);
        push(8'h40, 8'h10, 1'b0);
        pulse_start();
        check("t5_done_low", 32'(cfg_done), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check("t2_start_held", 32'(sccb_start), 32'd1);
        pulse_start();
        check("t5_busy_after_ignored_start", 32'(busy), 32'd1);
        wait_done("t2", 1000);
        check("t2_writes_left", 32'(exp_q.size()), 32'd0);
        check("t2_ready_wait", 32'(last_issue_len >= 50), 32'd1);
        ready_delay = 2;

        // Test 3: 256 plain entries, no end marker; address saturates at 255.
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            rom[i] = {b, ~b};
            push(b, ~b, 1'b0);
        end
        pulse_start();
        wait_done("t3", 20000);
        check("t3_writes_left", 32'(exp_q.size()), 32'd0);
        check("t3_rom_addr", 32'(rom_addr), 32'd255);
        repeat (5) @(negedge clk);
        check("t3_rom_addr_hold", 32'(rom_addr), 32'd255);
        check("t3_done_hold", 32'(cfg_done), 32'd1);

        // Test 4: reset during WAIT_DONE of entry 5, then automatic restart at 0.
        for (int i = 0; i < 8; i++) begin
            rom[i] = {8'h10 + 8'(i), 8'hA0 + 8'(i)};
        end
        rom[8] = 16'hFFFF;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b0);
        base = accept_cnt;
        pulse_start();
        n = 0;
        while (accept_cnt < base + 6 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_entry5", 32'(accept_cnt - base), 32'd6);
        repeat (3) @(negedge clk);
        check("t4_busy_before_reset", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset("t4_reset");
        check("t4_writes_left", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        wait_done("t4", 3000);
        check("t4_rerun_writes_left", 32'(exp_q.size()), 32'd0);
        check("t4_rom_addr", 32'(rom_addr), 32'd8);

        // Test 6: every attempt on entry 2 is NACKed.
`ifdef CAM_CFG_RETRY_EN
        attempts = 4;
        e3 = 1'b1;
`else
        attempts = 1;
        e3 = 1'b0;
`endif
        for (int i = 0; i < 4; i++) rom[i] = {8'h50 + 8'(i), 8'h60 + 8'(i)};
        rom[4] = 16'hFFFF;
        nack_addr = 2;
        push(8'h50, 8'h60, 1'b0);
        push(8'h51, 8'h61, 1'b0);
        for (int i = 0; i < attempts; i++) push(8'h52, 8'h62, 1'b0);
        push(8'h53, 8'h63, e3);
        pulse_start();
        wait_done("t6", 3000);
        check("t6_writes_left", 32'(exp_q.size()), 32'd0);
        check("t6_err", 32'(err), 32'(e3));

        // A new start clears o_err and reruns cleanly.
        nack_addr = -1;
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i), 8'h60 + 8'(i), 1'b0);
        pulse_start();
        check("final_err_cleared", 32'(err), 32'd0);
        wait_done("final", 3000);
        check("final_writes_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
